// File: rtl/ttt_pixel_renderer_if.sv
// Move request handshake between the game controller (master) and the
// tic-tac-toe renderer (slave).
interface ttt_move_if;
    logic       move_valid;
    logic [3:0] move_cell;
    logic       move_ready;

    modport master (output move_valid, output move_cell, input move_ready);
    modport slave  (input move_valid, input move_cell, output move_ready);
endinterface

// File: rtl/ttt_pixel_renderer.sv
// Tic-tac-toe board state machine and 1-cycle pixel renderer for the VGA path.
// Optional macro TTT_HOVER_EN adds a hover_cell input that tints one cell background.
module ttt_pixel_renderer #(
    parameter int BOARD_X0    = 140,
    parameter int BOARD_Y0    = 60,
    parameter int CELL_SIZE   = 120,
    parameter int LINE_W      = 4,
    parameter int MARK_MARGIN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  posx,
    input  logic [9:0]  posy,
    input  logic        blank_n_in,
    input  logic        new_game,
    ttt_move_if.slave   move_bus,
`ifdef TTT_HOVER_EN
    input  logic [3:0]  hover_cell,
`endif
    output logic        move_err,
    output logic        turn,
    output logic [1:0]  game_state,
    output logic [1:0]  winner,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        blank_n_out
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_DRAW  = 2'd3
    } state_e;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [9:0] X_B0  = 10'(BOARD_X0);
    localparam logic [9:0] X_B1  = 10'(BOARD_X0 + CELL_SIZE);
    localparam logic [9:0] X_B2  = 10'(BOARD_X0 + 2 * CELL_SIZE);
    localparam logic [9:0] X_B3  = 10'(BOARD_X0 + 3 * CELL_SIZE);
    localparam logic [9:0] Y_B0  = 10'(BOARD_Y0);
    localparam logic [9:0] Y_B1  = 10'(BOARD_Y0 + CELL_SIZE);
    localparam logic [9:0] Y_B2  = 10'(BOARD_Y0 + 2 * CELL_SIZE);
    localparam logic [9:0] Y_B3  = 10'(BOARD_Y0 + 3 * CELL_SIZE);
    localparam logic [9:0] LW    = 10'(LINE_W);
    localparam logic [9:0] IN_LO = 10'(MARK_MARGIN);
    localparam logic [9:0] IN_HI = 10'(CELL_SIZE - MARK_MARGIN);
    localparam logic [9:0] RI_LO = 10'(MARK_MARGIN + LINE_W);
    localparam logic [9:0] RI_HI = 10'(CELL_SIZE - MARK_MARGIN - LINE_W);
    localparam logic signed [10:0] DIAG_OFF = 11'(CELL_SIZE - 1);
    localparam logic signed [10:0] LW_SG    = 11'(LINE_W);

    // Cell masks of the eight winning lines in check-priority order.
    function automatic logic [8:0] line_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    line_mask = 9'h007;
            3'd1:    line_mask = 9'h038;
            3'd2:    line_mask = 9'h1C0;
            3'd3:    line_mask = 9'h049;
            3'd4:    line_mask = 9'h092;
            3'd5:    line_mask = 9'h124;
            3'd6:    line_mask = 9'h111;
            3'd7:    line_mask = 9'h054;
            default: line_mask = 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] mark_owned(input logic [8:0][1:0] board, input logic [1:0] mark);
        for (int i = 0; i < 9; i++) begin
            mark_owned[i] = (board[i] == mark);
        end
    endfunction

    function automatic logic signed [10:0] abs11(input logic signed [10:0] v);
        abs11 = (v < 11'sd0) ? -v : v;
    endfunction

    state_e           state_r, state_s;
    logic [8:0][1:0]  board_r, board_s;
    logic             turn_r, turn_s;
    logic [1:0]       winner_r, winner_s;
    logic [3:0]       move_count_r, move_count_s;
    logic [8:0]       win_mask_r, win_mask_s;
    logic             move_err_r, move_err_s;
    logic             move_ready_s;
    logic             cell_busy_s;
    logic [8:0]       owned_s;
    logic             line_hit_s;

    assign move_ready_s      = (state_r == ST_PLAY) && !new_game && !rst;
    assign move_bus.move_ready = move_ready_s;
    assign cell_busy_s = (move_bus.move_cell > 4'd8) ? 1'b1 : (board_r[move_bus.move_cell] != CELL_EMPTY);
    assign owned_s     = mark_owned(board_r, turn_r ? CELL_O : CELL_X);

    // Game next-state: move acceptance, line evaluation, win/draw hold.
    always_comb begin
        state_s      = state_r;
        board_s      = board_r;
        turn_s       = turn_r;
        winner_s     = winner_r;
        move_count_s = move_count_r;
        win_mask_s   = win_mask_r;
        move_err_s   = 1'b0;
        line_hit_s   = 1'b0;
        case (state_r)
            ST_PLAY: begin
                if (move_bus.move_valid && move_ready_s) begin
                    if (cell_busy_s) begin
                        move_err_s = 1'b1;
                    end else begin
                        board_s[move_bus.move_cell] = turn_r ? CELL_O : CELL_X;
                        move_count_s = move_count_r + 4'd1;
                        state_s      = ST_CHECK;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_CHECK: begin
                for (int i = 0; i < 8; i++) begin
                    if (!line_hit_s && ((owned_s & line_mask(3'(i))) == line_mask(3'(i)))) begin
                        line_hit_s = 1'b1;
                        win_mask_s = line_mask(3'(i));
                    end else begin
                        line_hit_s = line_hit_s;
                    end
                end
                if (line_hit_s) begin
                    winner_s = turn_r ? 2'd2 : 2'd1;
                    state_s  = ST_WIN;
                end else if (move_count_r == 4'd9) begin
                    state_s = ST_DRAW;
                end else begin
                    turn_s  = ~turn_r;
                    state_s = ST_PLAY;
                end
            end
            ST_WIN, ST_DRAW: state_s = state_r;
            default:         state_s = ST_PLAY;
        endcase
    end

    // Game state registers; new_game clears everything rst clears except the pixel path.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state_r      <= ST_PLAY;
            board_r      <= '0;
            turn_r       <= 1'b0;
            winner_r     <= 2'd0;
            move_count_r <= 4'd0;
            win_mask_r   <= 9'd0;
            move_err_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            board_r      <= board_s;
            turn_r       <= turn_s;
            winner_r     <= winner_s;
            move_count_r <= move_count_s;
            win_mask_r   <= win_mask_s;
            move_err_r   <= move_err_s;
        end
    end

    logic [1:0]  col_s, row_s;
    logic [9:0]  lx_s, ly_s;
    logic        inside_s, grid_s, inset_s, ring_in_s, x_stroke_s, o_stroke_s;
    logic        pix_win_s, hover_s;
    logic [3:0]  pix_cell_s;
    logic [1:0]  pix_val_s;
    logic signed [10:0] lx_sg_s, ly_sg_s;
    logic [23:0] rgb_s;
    logic [23:0] rgb_r;
    logic        blank_r;

    // Column index by comparison against the cell boundaries; 3 means outside.
    always_comb begin
        if (posx < X_B0) begin
            col_s = 2'd3; lx_s = 10'd0;
        end else if (posx < X_B1) begin
            col_s = 2'd0; lx_s = posx - X_B0;
        end else if (posx < X_B2) begin
            col_s = 2'd1; lx_s = posx - X_B1;
        end else if (posx < X_B3) begin
            col_s = 2'd2; lx_s = posx - X_B2;
        end else begin
            col_s = 2'd3; lx_s = 10'd0;
        end
    end

    // Row index, same scheme as the columns.
    always_comb begin
        if (posy < Y_B0) begin
            row_s = 2'd3; ly_s = 10'd0;
        end else if (posy < Y_B1) begin
            row_s = 2'd0; ly_s = posy - Y_B0;
        end else if (posy < Y_B2) begin
            row_s = 2'd1; ly_s = posy - Y_B1;
        end else if (posy < Y_B3) begin
            row_s = 2'd2; ly_s = posy - Y_B2;
        end else begin
            row_s = 2'd3; ly_s = 10'd0;
        end
    end

    assign inside_s   = (col_s != 2'd3) && (row_s != 2'd3);
    assign pix_cell_s = 4'(row_s) * 4'd3 + 4'(col_s);
    assign pix_val_s  = inside_s ? board_r[pix_cell_s] : CELL_EMPTY;
    assign pix_win_s  = inside_s ? (win_mask_r[pix_cell_s] && (state_r == ST_WIN)) : 1'b0;
    assign grid_s     = ((col_s != 2'd0) && (lx_s < LW)) || ((row_s != 2'd0) && (ly_s < LW));
    assign inset_s    = (lx_s >= IN_LO) && (lx_s < IN_HI) && (ly_s >= IN_LO) && (ly_s < IN_HI);
    assign ring_in_s  = (lx_s >= RI_LO) && (lx_s < RI_HI) && (ly_s >= RI_LO) && (ly_s < RI_HI);
    assign lx_sg_s    = $signed({1'b0, lx_s});
    assign ly_sg_s    = $signed({1'b0, ly_s});
    assign x_stroke_s = inset_s && ((abs11(lx_sg_s - ly_sg_s) < LW_SG) ||
                                    (abs11(lx_sg_s + ly_sg_s - DIAG_OFF) < LW_SG));
    assign o_stroke_s = inset_s && !ring_in_s;
`ifdef TTT_HOVER_EN
    assign hover_s = (state_r == ST_PLAY) && (hover_cell <= 4'd8) && (hover_cell == pix_cell_s);
`else
    assign hover_s = 1'b0;
`endif

    // Colour selection in priority order: blanking, outside, grid, marks, background.
    always_comb begin
        rgb_s = 24'h000000;
        if (!blank_n_in) begin
            rgb_s = 24'h000000;
        end else if (!inside_s) begin
            rgb_s = 24'h000000;
        end else if (grid_s) begin
            rgb_s = (state_r == ST_DRAW) ? 24'hFFFF00 : 24'hFFFFFF;
        end else if ((pix_val_s == CELL_X) && x_stroke_s) begin
            rgb_s = pix_win_s ? 24'h00FF00 : 24'hFF0000;
        end else if ((pix_val_s == CELL_O) && o_stroke_s) begin
            rgb_s = pix_win_s ? 24'h00FF00 : 24'h0000FF;
        end else if (hover_s) begin
            rgb_s = 24'h303030;
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Pixel output registers: one cycle of latency, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_r   <= 24'h000000;
            blank_r <= 1'b0;
        end else begin
            rgb_r   <= rgb_s;
            blank_r <= blank_n_in;
        end
    end

    assign VGA_R       = rgb_r[23:16];
    assign VGA_G       = rgb_r[15:8];
    assign VGA_B       = rgb_r[7:0];
    assign blank_n_out = blank_r;
    assign move_err    = move_err_r;
    assign turn        = turn_r;
    assign game_state  = state_r;
    assign winner      = winner_r;

endmodule

// File: tb/tb_ttt_pixel_renderer.sv
// Directed self-checking bench for ttt_pixel_renderer with a pixel scoreboard queue.
module tb_ttt_pixel_renderer;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  posx, posy;
    logic        blank_n_in;
    logic        new_game;
    logic        move_err, turn;
    logic [1:0]  game_state, winner;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        blank_n_out;
    int          passed = 0;
    int          total  = 0;
    logic [24:0] sb[$];

    ttt_move_if move_bus ();

    ttt_pixel_renderer dut (
        .clk(clk), .rst(rst), .posx(posx), .posy(posy), .blank_n_in(blank_n_in),
        .new_game(new_game), .move_bus(move_bus), .move_err(move_err), .turn(turn),
        .game_state(game_state), .winner(winner), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .blank_n_out(blank_n_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one pixel, queue its expected result, compare one cycle later.
    task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic b, input logic [23:0] exp_rgb, input logic exp_blank);
        logic [24:0] e;
        posx = x; posy = y; blank_n_in = b;
        sb.push_back({exp_blank, exp_rgb});
        tick();
        e = sb.pop_front();
        check({tag, "_rgb"}, {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e[23:0]});
        check({tag, "_blank"}, {31'd0, blank_n_out}, {31'd0, e[24]});
    endtask

    // Full legal move: accept edge plus the CHECK cycle.
    task automatic move(input logic [3:0] c);
        move_bus.move_valid = 1'b1;
        move_bus.move_cell  = c;
        tick();
        move_bus.move_valid = 1'b0;
        tick();
    endtask

    task automatic clear_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; blank_n_in = 1'b1; posx = 10'd0; posy = 10'd0;
        move_bus.move_valid = 1'b0; move_bus.move_cell = 4'd0;
        tick(); tick();

        for (int y = 0; y < 480; y += 120) begin
            for (int x = 0; x < 640; x += 160) begin
                pix("reset_sweep", 10'(x + 60), 10'(y + 60), 1'b1, 24'h000000, 1'b0);
            end
        end
        check("reset_turn", {31'd0, turn}, 32'd0);
        check("reset_state", {30'd0, game_state}, 32'd0);
        check("reset_winner", {30'd0, winner}, 32'd0);
        check("reset_err", {31'd0, move_err}, 32'd0);
        check("reset_ready", {31'd0, move_bus.move_ready}, 32'd0);

        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, move_bus.move_ready}, 32'd1);
        pix("bg_300_70", 10'd300, 10'd70, 1'b1, 24'h000000, 1'b1);
        pix("grid_260_100", 10'd260, 10'd100, 1'b1, 24'hFFFFFF, 1'b1);

        move_bus.move_valid = 1'b1; move_bus.move_cell = 4'd4;
        tick();
        move_bus.move_valid = 1'b0;
        check("check_state", {30'd0, game_state}, 32'd1);
        check("check_ready", {31'd0, move_bus.move_ready}, 32'd0);
        check("check_turn", {31'd0, turn}, 32'd0);
        tick();
        check("play_state", {30'd0, game_state}, 32'd0);
        check("turn_o", {31'd0, turn}, 32'd1);
        pix("x_centre4", 10'd320, 10'd240, 1'b1, 24'hFF0000, 1'b1);

        for (int k = 0; k < 2; k++) begin
            move_bus.move_valid = 1'b1; move_bus.move_cell = (k == 0) ? 4'd4 : 4'd12;
            tick();
            move_bus.move_valid = 1'b0;
            check("illegal_err", {31'd0, move_err}, 32'd1);
            check("illegal_state", {30'd0, game_state}, 32'd0);
            check("illegal_turn", {31'd0, turn}, 32'd1);
            tick();
            check("illegal_err_drop", {31'd0, move_err}, 32'd0);
        end
        pix("x_kept4", 10'd320, 10'd240, 1'b1, 24'hFF0000, 1'b1);

        new_game = 1'b1;
        #1;
        check("ready_newgame", {31'd0, move_bus.move_ready}, 32'd0);
        tick();
        new_game = 1'b0;
        check("ng_state", {30'd0, game_state}, 32'd0);
        check("ng_turn", {31'd0, turn}, 32'd0);
        pix("ng_cell4_empty", 10'd320, 10'd240, 1'b1, 24'h000000, 1'b1);

        move(4'd0); move(4'd3); move(4'd1); move(4'd4); move(4'd2);
        check("win_winner", {30'd0, winner}, 32'd1);
        check("win_state", {30'd0, game_state}, 32'd2);
        check("win_ready", {31'd0, move_bus.move_ready}, 32'd0);
        pix("win_x0", 10'd200, 10'd120, 1'b1, 24'h00FF00, 1'b1);
        pix("win_x1", 10'd320, 10'd120, 1'b1, 24'h00FF00, 1'b1);
        pix("win_x1_diag", 10'd280, 10'd80, 1'b1, 24'h00FF00, 1'b1);
        pix("win_o3", 10'd156, 10'd240, 1'b1, 24'h0000FF, 1'b1);
        pix("win_o4", 10'd276, 10'd240, 1'b1, 24'h0000FF, 1'b1);
        pix("win_grid", 10'd260, 10'd100, 1'b1, 24'hFFFFFF, 1'b1);
        move_bus.move_valid = 1'b1; move_bus.move_cell = 4'd5;
        tick();
        move_bus.move_valid = 1'b0;
        check("win_hold_state", {30'd0, game_state}, 32'd2);
        check("win_hold_err", {31'd0, move_err}, 32'd0);

        clear_game();
        move(4'd0); move(4'd1); move(4'd2); move(4'd4); move(4'd3);
        move(4'd5); move(4'd7); move(4'd6); move(4'd8);
        check("draw_state", {30'd0, game_state}, 32'd3);
        check("draw_winner", {30'd0, winner}, 32'd0);
        pix("draw_grid", 10'd260, 10'd100, 1'b1, 24'hFFFF00, 1'b1);
        pix("draw_x0", 10'd200, 10'd120, 1'b1, 24'hFF0000, 1'b1);
        clear_game();
        check("draw_ng_state", {30'd0, game_state}, 32'd0);
        check("draw_ng_turn", {31'd0, turn}, 32'd0);
        check("draw_ng_winner", {30'd0, winner}, 32'd0);
        pix("draw_ng_empty0", 10'd200, 10'd120, 1'b1, 24'h000000, 1'b1);

        move(4'd4);
        move_bus.move_valid = 1'b1; move_bus.move_cell = 4'd0; new_game = 1'b1;
        tick();
        move_bus.move_valid = 1'b0; new_game = 1'b0;
        check("sim_state", {30'd0, game_state}, 32'd0);
        check("sim_turn", {31'd0, turn}, 32'd0);
        check("sim_err", {31'd0, move_err}, 32'd0);
        pix("sim_cell0", 10'd200, 10'd120, 1'b1, 24'h000000, 1'b1);
        pix("sim_cell4", 10'd320, 10'd240, 1'b1, 24'h000000, 1'b1);

        move(4'd4);
        pix("blank_mark", 10'd320, 10'd240, 1'b0, 24'h000000, 1'b0);
        pix("unblank_mark", 10'd320, 10'd240, 1'b1, 24'hFF0000, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
